// File: rtl/qdr_sram_responder.sv
// Burst-of-2 QDR SRAM responder: on-chip array, fixed-latency read pipe.
// Define QDR_SRAM_RESPONDER_ERR_EN to enable the protocol violation flags/counter.
module qdr_sram_responder #(
   parameter int QDR_LATENCY  = 12,
   parameter int ADDR_BITS    = 11,
   parameter int DATA_WIDTH   = 36,
   parameter int ERR_CNT_BITS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    qdr_we,
   input  logic                    qdr_re,
   input  logic [ADDR_BITS-1:0]    qdr_addr,
   input  logic [DATA_WIDTH-1:0]   qdr_d,
   output logic [DATA_WIDTH-1:0]   qdr_q,
   output logic                    qdr_q_vld,
   output logic                    err_clash,
   output logic                    err_burst,
   output logic [ERR_CNT_BITS-1:0] err_cnt
);

   localparam int DEPTH = 2 ** (ADDR_BITS + 1);
   // the output register is the last of the QDR_LATENCY stages
   localparam int PIPE  = QDR_LATENCY - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR1  = 2'd1,
      S_RD1  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   mem_we;
   logic                   mem_re;
   logic [ADDR_BITS:0]     mem_idx;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [DATA_WIDTH-1:0]  dat_q [PIPE];
   logic [PIPE-1:0]        vld_q;
   logic [DATA_WIDTH-1:0]  qdr_q_q;
   logic                   qdr_q_vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (ce) begin
         unique case (state_q)
            S_IDLE: begin
               if (qdr_we)
                  state_d = S_WR1;
               else if (qdr_re)
                  state_d = S_RD1;
            end
            S_WR1:   state_d = S_IDLE;
            S_RD1:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // a write wins over a simultaneous read; second-cycle commands are ignored
   always_comb begin
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      mem_idx = {qdr_addr, 1'b0};
      addr_d  = addr_q;
      if (ce && !rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (qdr_we) begin
                  mem_we = 1'b1;
                  addr_d = qdr_addr;
               end else if (qdr_re) begin
                  mem_re = 1'b1;
                  addr_d = qdr_addr;
               end
            end
            S_WR1: begin
               mem_we  = 1'b1;
               mem_idx = {addr_q, 1'b1};
            end
            S_RD1: begin
               mem_re  = 1'b1;
               mem_idx = {addr_q, 1'b1};
            end
            default: ;
         endcase
      end
   end

   // array and pipe data carry no reset so the array maps to block RAM
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_idx] <= qdr_d;
      if (ce) begin
         if (mem_re)
            dat_q[0] <= mem[mem_idx];
         for (int i = 1; i < PIPE; i++)
            dat_q[i] <= dat_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         qdr_q_q     <= '0;
         qdr_q_vld_q <= 1'b0;
      end else if (ce) begin
         vld_q       <= {vld_q[PIPE-2:0], mem_re};
         qdr_q_vld_q <= vld_q[PIPE-1];
         if (vld_q[PIPE-1])
            qdr_q_q <= dat_q[PIPE-1];
      end
   end

   assign qdr_q     = qdr_q_q;
   assign qdr_q_vld = qdr_q_vld_q;

`ifdef QDR_SRAM_RESPONDER_ERR_EN
   logic                    viol_clash;
   logic                    viol_burst;
   logic                    err_clash_q;
   logic                    err_burst_q;
   logic [ERR_CNT_BITS-1:0] err_cnt_q;

   assign viol_clash = ce & qdr_we & qdr_re;
   assign viol_burst = ce & (state_q != S_IDLE) & (qdr_we | qdr_re);

   // a cycle with both violations still counts once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_clash_q <= 1'b0;
         err_burst_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         if (viol_clash)
            err_clash_q <= 1'b1;
         if (viol_burst)
            err_burst_q <= 1'b1;
         if ((viol_clash || viol_burst) && !(&err_cnt_q))
            err_cnt_q <= err_cnt_q + ERR_CNT_BITS'(1);
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && (viol_clash || viol_burst))
         $display("%0t qdr_sram_responder violation addr=%0h", $time, qdr_addr);
   end
`endif

   assign err_clash = err_clash_q;
   assign err_burst = err_burst_q;
   assign err_cnt   = err_cnt_q;
`else
   assign err_clash = 1'b0;
   assign err_burst = 1'b0;
   assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_qdr_sram_responder.sv
// Directed bench for qdr_sram_responder: latency, RAW, wrap, violations,
// reset mid-operation and ce gating.
module tb_qdr_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        qdr_we;
   logic        qdr_re;
   logic [10:0] qdr_addr;
   logic [35:0] qdr_d;
   logic [35:0] qdr_q;
   logic        qdr_q_vld;
   logic        err_clash;
   logic        err_burst;
   logic [15:0] err_cnt;

`ifdef QDR_SRAM_RESPONDER_ERR_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [35:0] expq [$];
   int n_pop = 0;

   qdr_sram_responder dut (
      .clk(clk), .rst(rst), .ce(ce),
      .qdr_we(qdr_we), .qdr_re(qdr_re), .qdr_addr(qdr_addr),
      .qdr_d(qdr_d), .qdr_q(qdr_q), .qdr_q_vld(qdr_q_vld),
      .err_clash(err_clash), .err_burst(err_burst), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_s();
      tick();
      if (qdr_q_vld) begin
         if (expq.size() == 0)
            chk("stream_extra_vld", 64'd1, 64'd0);
         else begin
            chk("stream_data", qdr_q, expq.pop_front());
            n_pop++;
         end
      end
   endtask

   task automatic wr(input logic [10:0] a, input logic [35:0] d0,
                     input logic [35:0] d1);
      qdr_we = 1'b1; qdr_addr = a; qdr_d = d0;
      tick();
      qdr_we = 1'b0; qdr_d = d1;
      tick();
      qdr_d = '0;
   endtask

   task automatic rd_expect(input string tag, input logic [10:0] a,
                            input logic [35:0] e0, input logic [35:0] e1);
      logic seen;
      seen = 1'b0;
      qdr_re = 1'b1; qdr_addr = a;
      tick();
      qdr_re = 1'b0;
      seen |= qdr_q_vld;
      for (int t = 2; t <= 11; t++) begin
         tick();
         seen |= qdr_q_vld;
      end
      chk({tag, "_early_vld"}, seen, 1'b0);
      tick();
      chk({tag, "_w0_vld"}, qdr_q_vld, 1'b1);
      chk({tag, "_w0"}, qdr_q, e0);
      tick();
      chk({tag, "_w1_vld"}, qdr_q_vld, 1'b1);
      chk({tag, "_w1"}, qdr_q, e1);
      tick();
      chk({tag, "_vld_off"}, qdr_q_vld, 1'b0);
      chk({tag, "_hold"}, qdr_q, e1);
   endtask

   initial begin
      logic        seen;
      int          nv;
      logic [35:0] v0, v1;
      logic [10:0] a;

      rst = 1'b1; ce = 1'b1; qdr_we = 1'b0; qdr_re = 1'b0;
      qdr_addr = '0; qdr_d = '0;
      tick(); tick();
      chk("rst_q", qdr_q, 36'd0);
      chk("rst_vld", qdr_q_vld, 1'b0);
      chk("rst_clash", err_clash, 1'b0);
      chk("rst_burst", err_burst, 1'b0);
      chk("rst_cnt", err_cnt, 16'd0);
      rst = 1'b0;
      tick();

      // write then read, minimum spacing
      wr(11'd5, 36'h111, 36'h222);
      rd_expect("wr_rd", 11'd5, 36'h111, 36'h222);

      // clash: write executes, read dropped
      qdr_we = 1'b1; qdr_re = 1'b1; qdr_addr = 11'd9; qdr_d = 36'hA;
      tick();
      qdr_we = 1'b0; qdr_re = 1'b0; qdr_d = 36'hB;
      tick();
      qdr_d = '0;
      seen = 1'b0;
      for (int t = 0; t < 14; t++) begin
         tick();
         seen |= qdr_q_vld;
      end
      chk("clash_no_vld", seen, 1'b0);
      chk("clash_flag", err_clash, EN);
      chk("clash_no_burst", err_burst, 1'b0);
      chk("clash_cnt", err_cnt, EN ? 16'd1 : 16'd0);
      rd_expect("clash_mem", 11'd9, 36'hA, 36'hB);

      // burst violation: second read ignored
      wr(11'd3, 36'h333, 36'h334);
      wr(11'd4, 36'h444, 36'h445);
      qdr_re = 1'b1; qdr_addr = 11'd3;
      tick();
      qdr_addr = 11'd4;
      tick();
      qdr_re = 1'b0;
      nv = 0; v0 = '0; v1 = '0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (qdr_q_vld) begin
            if (nv == 0) v0 = qdr_q;
            if (nv == 1) v1 = qdr_q;
            nv++;
         end
      end
      chk("burst_nvld", nv, 2);
      chk("burst_w0", v0, 36'h333);
      chk("burst_w1", v1, 36'h334);
      chk("burst_flag", err_burst, EN);
      chk("burst_cnt", err_cnt, EN ? 16'd2 : 16'd0);

      // reset mid-read
      wr(11'd7, 36'h777, 36'h778);
      qdr_re = 1'b1; qdr_addr = 11'd7;
      tick();
      qdr_re = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      rst = 1'b1;
      #1;
      chk("rstmid_q", qdr_q, 36'd0);
      chk("rstmid_vld", qdr_q_vld, 1'b0);
      chk("rstmid_clash", err_clash, 1'b0);
      chk("rstmid_burst", err_burst, 1'b0);
      chk("rstmid_cnt", err_cnt, 16'd0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         seen |= qdr_q_vld;
      end
      chk("rstmid_no_vld", seen, 1'b0);
      rd_expect("rstmid_keep", 11'd7, 36'h777, 36'h778);

      // reset during WR1: word0 committed, word1 not
      wr(11'd8, 36'h881, 36'h882);
      qdr_we = 1'b1; qdr_addr = 11'd8; qdr_d = 36'h991;
      tick();
      qdr_we = 1'b0; qdr_d = 36'h992;
      rst = 1'b1;
      tick();
      rst = 1'b0; qdr_d = '0;
      tick();
      rd_expect("rstwr", 11'd8, 36'h991, 36'h882);

      // ce gating inside the pipe and on the output
      wr(11'd10, 36'hAA1, 36'hAA2);
      seen = 1'b0;
      qdr_re = 1'b1; qdr_addr = 11'd10;
      tick();
      qdr_re = 1'b0;
      seen |= qdr_q_vld;
      for (int t = 2; t <= 5; t++) begin
         tick();
         seen |= qdr_q_vld;
      end
      ce = 1'b0;
      for (int t = 6; t <= 9; t++) begin
         qdr_re = 1'b1; qdr_addr = 11'd11;
         tick();
         seen |= qdr_q_vld;
      end
      qdr_re = 1'b0;
      ce = 1'b1;
      for (int t = 10; t <= 15; t++) begin
         tick();
         seen |= qdr_q_vld;
      end
      chk("ce_early_vld", seen, 1'b0);
      tick();
      chk("ce_w0_vld", qdr_q_vld, 1'b1);
      chk("ce_w0", qdr_q, 36'hAA1);
      ce = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      chk("ce_hold_vld", qdr_q_vld, 1'b1);
      chk("ce_hold_q", qdr_q, 36'hAA1);
      ce = 1'b1;
      tick();
      chk("ce_w1_vld", qdr_q_vld, 1'b1);
      chk("ce_w1", qdr_q, 36'hAA2);
      tick();
      chk("ce_vld_off", qdr_q_vld, 1'b0);

      // streaming write/read over the whole range plus wrap
      for (int k = 0; k < 2050; k++) begin
         a  = 11'(k);
         v0 = {4'h5, 20'(k), 12'h0A0};
         v1 = {4'hC, 20'(k), 12'h0B1};
         qdr_we = 1'b1; qdr_addr = a; qdr_d = v0;
         tick_s();
         qdr_we = 1'b0; qdr_d = v1;
         tick_s();
         qdr_d = '0;
         qdr_re = 1'b1; qdr_addr = a;
         expq.push_back(v0);
         expq.push_back(v1);
         tick_s();
         qdr_re = 1'b0;
         tick_s();
      end
      for (int t = 0; t < 16; t++) tick_s();
      chk("stream_drain", expq.size(), 0);
      chk("stream_count", n_pop, 4100);
      chk("stream_no_err", err_cnt, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/qdr_sram_responder.md
# qdr_sram_responder

Synthesizable burst-of-2 QDR SRAM responder for the vector-accumulator datapath.
- Sits on the memory side of the vacc controller's single-address QDR command interface (`qdr_we`, `qdr_re`, `qdr_addr`), in place of an external QDR part, for small builds and for simulation.
- Holds two DATA_WIDTH words per address in on-chip RAM, captures write bursts, and returns read bursts after a fixed QDR_LATENCY.
- Detects command-protocol violations.

## Interface
- QDR_LATENCY, 12: cycles from read command to first read word; legal range ≥ 3.
- ADDR_BITS, 11: QDR address width; depth is 2^ADDR_BITS burst slots.
- DATA_WIDTH, 36: width of one word.
- ERR_CNT_BITS, 16: width of the violation counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ce  in  1  clock enable; gates command acceptance and pipeline advance.
- qdr_we  in  1  write command.
- qdr_re  in  1  read command.
- qdr_addr  in  ADDR_BITS  burst address shared by read and write.
- qdr_d  in  DATA_WIDTH  write data; word0 in command cycle, word1 in the next ce cycle.
- qdr_q  out  DATA_WIDTH  read data.
- qdr_q_vld  out  1  qdr_q valid, high for exactly two ce cycles per accepted read.
- err_clash  out  1  sticky flag: we and re asserted together.
- err_burst  out  1  sticky flag: command in the cycle after an accepted command.
- err_cnt  out  ERR_CNT_BITS  count of violations, saturating.

## Operation
Command phase FSM (states advance only on ce-high cycles):
- IDLE
  - we=1: latch addr, write word0 to {addr,0}, go to WR1.
  - re=1 and we=0: read slot addr, push read token into latency pipe, go to RD1.
- WR1: write qdr_d to {addr,1}; go to IDLE.
- RD1: second read word enters pipe; go to IDLE.

Command rules:
- Commands are legal only in IDLE, so the minimum command spacing is 2 ce cycles.
- Command (we or re) seen in WR1 or RD1: ignored, err_burst set, err_cnt +1. The FSM still returns to IDLE.
- we and re together in IDLE: write executes, read is dropped, err_clash set, err_cnt +1.
- Both violations in one cycle (possible only in WR1/RD1): err_cnt increments by 1 only.

Read pipe:
- QDR_LATENCY-stage shift register of {valid, data}.
- Word0 appears on qdr_q at command cycle + QDR_LATENCY; word1 one ce cycle later.

Memory behaviour:
- Memory is not cleared by reset; contents persist across rst.
- Read-after-write: a read accepted 2 ce cycles after a write to the same addr returns the new word0 and word1.
- Address wrap: the full 2^ADDR_BITS range is valid; no out-of-range condition exists.

Output values:
- qdr_q holds its last value when qdr_q_vld=0.

## Timing
- Reset values: qdr_q=0, qdr_q_vld=0, err_clash=0, err_burst=0, err_cnt=0. FSM returns to IDLE and the read pipe valid bits clear.
- Reset mid-operation:
  - In-flight reads are discarded; no qdr_q_vld after rst deasserts.
  - A write interrupted in WR1 has word0 committed; word1 is not committed.
- ce=0: no state changes. The pipe holds and outputs hold. A held qdr_q_vld stays high until the next ce cycle.
- Latency counts only ce-high cycles.
- Read pipe outputs are registered; the array read is registered inside the pipe.
- err_cnt saturates at 2^ERR_CNT_BITS-1.

## Configuration
Macro: QDR_SRAM_RESPONDER_ERR_EN
- Defined:
  - err_clash, err_burst and err_cnt operate as described.
  - The simulation build also prints time and addr on each violation.
- Undefined:
  - The three error outputs are tied to 0 and the counter logic is removed.
  - Violating commands are still filtered exactly as above, so memory behaviour is identical in both builds.

## Test plan
- Write then read:
  - Stimulus: we at addr 5 with qdr_d=0x111 then 0x222; re at addr 5 two cycles later.
  - Required: qdr_q=0x111 at re+12 and 0x222 at re+13, with qdr_q_vld high exactly those 2 cycles.
- Back-to-back streaming:
  - Stimulus: alternating re/we every 2 cycles over addrs 0..2047, mimicking vacc traffic.
  - Required: every read returns the most recent write; the address wraps from 2047 to 0 cleanly.
- Clash:
  - Stimulus: we=re=1 at addr 9 with data 0xA, 0xB.
  - Required: memory slot 9 = {0xA, 0xB}; no qdr_q_vld; err_clash=1; err_cnt=1.
- Burst violation:
  - Stimulus: re at addr 3, then re at addr 4 on the next cycle.
  - Required: only addr 3 is returned (2 vld cycles); err_burst=1; err_cnt=1.
- Reset mid-read:
  - Stimulus: re at addr 7, rst pulsed 5 cycles later.
  - Required: all outputs 0 immediately; no qdr_q_vld for 20 cycles after rst; a subsequent read of addr 7 returns the pre-reset data.
- ce gating:
  - Stimulus: re, then ce low for 4 cycles during the pipe.
  - Required: word0 arrives at 12 ce-high cycles (16 clocks); qdr_q_vld stays held while ce=0.
